mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single CPU memory bus (address, size, mem_read, mem_write, 64-bit data) between two requesters: instruction fetch (IF) and load/store (LS) from the control unit.
- Sits between the control unit and the datapath/memory boundary.
- Sequences each access over a fixed number of memory cycles, checks alignment, and returns read data with a one-cycle acknowledge.
- Arbitration is round-robin when both requesters are pending.

Parameters:
- MEM_LAT, 2, cycles mem_read/mem_write are held per access; legal range 1..15; read data sampled on the last of these cycles.
- ADDR_W, 32, address width.
- DATA_W, 64, data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- if_req  input  1  IF access request (read, 32-bit word).
- if_addr  input  ADDR_W  IF byte address.
- if_rdata  output  DATA_W  fetched data, zero-extended word; valid while if_ack=1.
- if_ack  output  1  one-cycle completion pulse to IF.
- if_err  output  1  misaligned IF access; qualifies if_ack.
- ls_req  input  1  LS access request.
- ls_we  input  1  1=store, 0=load.
- ls_size  input  2  00 byte, 01 half, 10 word, 11 double.
- ls_addr  input  ADDR_W  LS byte address.
- ls_wdata  input  DATA_W  store data.
- ls_rdata  output  DATA_W  load data; valid while ls_ack=1.
- ls_ack  output  1  one-cycle completion pulse to LS.
- ls_err  output  1  misaligned LS access; qualifies ls_ack.
- address  output  ADDR_W  memory address.
- size  output  2  memory access size.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_wdata  output  DATA_W  store data to the bus driver.
- mem_wdata_oe  output  1  bus drive enable; equals mem_write.
- mem_rdata  input  DATA_W  memory read data.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- All outputs are registered.
- **Reset** (reset=0, asynchronous): state=IDLE; all outputs 0; rr pointer = IF-preferred. Reset mid-access aborts immediately: strobes drop, no ack is ever issued for that access.
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - Sample if_req/ls_req.
  - If only one is high, grant it. If both are high, grant the side not granted last (rr pointer), then flip the pointer to the other side.
  - On grant, latch: address, size (IF forces 2'b10), we (IF forces 0), wdata, and requester id.
  - Alignment check: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0.
  - Aligned: go to ACCESS with cnt=MEM_LAT-1. Misaligned: go directly to RESP with err=1; no memory strobe is asserted.
- **ACCESS:**
  - mem_read=~we, mem_write=we, mem_wdata_oe=we; address/size/mem_wdata hold the latched values for exactly MEM_LAT cycles.
  - cnt decrements each cycle. When cnt==0, capture mem_rdata (loads only) and go to RESP.
- **RESP:**
  - Strobes low. Granted side's ack=1 for exactly one cycle; err=1 only if misaligned.
  - rdata holds the captured value. For stores, rdata keeps its previous value.
  - Next state is IDLE.
- **Timing:** a request sampled in IDLE at edge k gives strobes high over cycles k+1..k+MEM_LAT and ack in cycle k+MEM_LAT+1. A misaligned request gives ack+err in cycle k+1.
- **Throughput:** minimum period is MEM_LAT+2 cycles per access.
- **Requester rules:**
  - Hold req and operands stable until ack.
  - Update req at the edge ending the ack cycle; the following IDLE cycle sees the new intent.
  - Requests are ignored in ACCESS and RESP. Dropping req mid-access does not cancel it; the ack is still issued.
- **Other outputs:** address/size/mem_wdata return to 0 outside ACCESS. busy is high in ACCESS and RESP.
- **Data widths:**
  - Loads: ls_rdata is the full 64-bit mem_rdata, unmodified; byte/half/word extension belongs to the datapath.
  - Fetches: if_rdata = {32'b0, mem_rdata[31:0]}.

Test Plan:
- Reset, then if_req=1 with if_addr=0x100 (MEM_LAT=2) -> mem_read high 2 cycles, address=0x100, size=10; if_ack one cycle later with if_rdata=0x0000_0000_DEAD_BEEF for mem_rdata=0x1234_5678_DEAD_BEEF.
- ls_req=1, ls_we=1, ls_size=11, ls_addr=0x208, ls_wdata=0xA5A5_0000_FFFF_0001 -> mem_write and mem_wdata_oe high 2 cycles with exact data; ls_ack=1, ls_err=0, mem_read never high.
- if_req and ls_req both held high from reset for 4 accesses -> grant order IF, LS, IF, LS; each ack exactly MEM_LAT+2 cycles apart.
- ls_size=10 with ls_addr=0x202 -> ls_ack and ls_err high in the cycle after sampling; no strobes; next IDLE accepts a new request.
- reset=0 asserted in the 2nd ACCESS cycle of a load -> mem_read drops asynchronously, no ls_ack; after release, the held ls_req (aligned, 0x300) completes normally.
- MEM_LAT=1 build: load from 0x10 -> mem_read high one cycle, ls_ack the next cycle; busy high for exactly 2 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter for the single CPU memory bus.
// Round-robin grant, alignment check, fixed-latency access and a one-cycle ack.
module mem_bus_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ack,
  output logic              ls_err,
  output logic [ADDR_W-1:0] address,
  output logic [1:0]        size,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rr_ls;
  logic               r_we;
  logic               r_id_ls;

  logic               w_grant_any;
  logic               w_grant_ls;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [1:0]         w_sel_size;
  logic               w_sel_we;
  logic [DATA_W-1:0]  w_sel_wdata;
  logic               w_misalign;

  // Grant selection: LS wins when it is alone or when the pointer prefers it.
  assign w_grant_any = if_req | ls_req;
  assign w_grant_ls  = ls_req & (~if_req | r_rr_ls);
  assign w_sel_addr  = w_grant_ls ? ls_addr : if_addr;
  assign w_sel_size  = w_grant_ls ? ls_size : 2'b10;
  assign w_sel_we    = w_grant_ls & ls_we;
  assign w_sel_wdata = w_grant_ls ? ls_wdata : '0;

  always_comb begin
    w_misalign = 1'b0;
    case (w_sel_size)
      2'b01:   w_misalign = w_sel_addr[0];
      2'b10:   w_misalign = |w_sel_addr[1:0];
      2'b11:   w_misalign = |w_sel_addr[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rr_ls      <= 1'b0;
      r_we         <= 1'b0;
      r_id_ls      <= 1'b0;
      if_rdata     <= '0;
      if_ack       <= 1'b0;
      if_err       <= 1'b0;
      ls_rdata     <= '0;
      ls_ack       <= 1'b0;
      ls_err       <= 1'b0;
      address      <= '0;
      size         <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      ls_ack <= 1'b0;
      ls_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_any) begin
            r_id_ls <= w_grant_ls;
            r_rr_ls <= ~w_grant_ls;
            r_we    <= w_sel_we;
            busy    <= 1'b1;
            if (w_misalign) begin
              // Misaligned: answer immediately, never touch the bus.
              r_state <= RESP;
              if_ack  <= ~w_grant_ls;
              if_err  <= ~w_grant_ls;
              ls_ack  <= w_grant_ls;
              ls_err  <= w_grant_ls;
            end else begin
              r_state      <= ACCESS;
              r_cnt        <= CNT_W'(MEM_LAT - 1);
              address      <= w_sel_addr;
              size         <= w_sel_size;
              mem_read     <= ~w_sel_we;
              mem_write    <= w_sel_we;
              mem_wdata_oe <= w_sel_we;
              mem_wdata    <= w_sel_wdata;
            end
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state      <= RESP;
            address      <= '0;
            size         <= '0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wdata_oe <= 1'b0;
            mem_wdata    <= '0;
            if_ack       <= ~r_id_ls;
            ls_ack       <= r_id_ls;
            if (!r_we) begin
              if (r_id_ls) ls_rdata <= mem_rdata;
              else         if_rdata <= DATA_W'(mem_rdata[WORD_W-1:0]);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 side instance).
module tb_mem_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [63:0] if_rdata;
  logic        if_ack;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [63:0] ls_rdata;
  logic        ls_ack;
  logic        ls_err;
  logic [31:0] address;
  logic [1:0]  size;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic        mem_wdata_oe;
  logic [63:0] mem_rdata;
  logic        busy;

  logic [63:0] d1_if_rdata;
  logic        d1_if_ack;
  logic        d1_if_err;
  logic [63:0] d1_ls_rdata;
  logic        d1_ls_ack;
  logic        d1_ls_err;
  logic [31:0] d1_address;
  logic [1:0]  d1_size;
  logic        d1_mem_read;
  logic        d1_mem_write;
  logic [63:0] d1_mem_wdata;
  logic        d1_mem_wdata_oe;
  logic        d1_busy;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(.MEM_LAT(2), .ADDR_W(32), .DATA_W(64)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack), .ls_err(ls_err),
    .address(address), .size(size), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_bus_arbiter #(.MEM_LAT(1), .ADDR_W(32), .DATA_W(64)) dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(d1_if_rdata), .if_ack(d1_if_ack), .if_err(d1_if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(d1_ls_rdata), .ls_ack(d1_ls_ack), .ls_err(d1_ls_err),
    .address(d1_address), .size(d1_size), .mem_read(d1_mem_read), .mem_write(d1_mem_write),
    .mem_wdata(d1_mem_wdata), .mem_wdata_oe(d1_mem_wdata_oe), .mem_rdata(mem_rdata), .busy(d1_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h100;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_wdata_oe !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got rd=%0b wr=%0b oe=%0b expected 0", mem_read, mem_write, mem_wdata_oe); end
    checks++; if (if_ack !== 1'b0 || ls_ack !== 1'b0 || if_err !== 1'b0 || ls_err !== 1'b0) begin
      errors++; $display("FAIL reset_acks: got if_ack=%0b ls_ack=%0b expected 0", if_ack, ls_ack); end
    checks++; if (address !== 32'h0 || size !== 2'b00 || mem_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_bus: got addr=%0h size=%0h wdata=%0h expected 0", address, size, mem_wdata); end
    checks++; if (if_rdata !== 64'h0 || ls_rdata !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got if=%0h ls=%0h expected 0", if_rdata, ls_rdata); end
    if_req = 1'b0;
  endtask

  task automatic test_if_fetch();
    apply_reset();
    mem_rdata = 64'h1234_5678_DEAD_BEEF;
    if_addr = 32'h100;
    if_req = 1'b1;
    @(posedge clock); #1;
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL if_strobe1: got rd=%0b wr=%0b expected rd=1 wr=0", mem_read, mem_write); end
    checks++; if (address !== 32'h100 || size !== 2'b10) begin
      errors++; $display("FAIL if_addr_size: got addr=%0h size=%0h expected 100/2", address, size); end
    checks++; if (busy !== 1'b1 || if_ack !== 1'b0) begin
      errors++; $display("FAIL if_busy1: got busy=%0b ack=%0b expected busy=1 ack=0", busy, if_ack); end
    @(posedge clock); #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL if_strobe2: got %0b expected 1", mem_read); end
    @(posedge clock); #1;
    checks++; if (mem_read !== 1'b0 || address !== 32'h0) begin
      errors++; $display("FAIL if_strobe_end: got rd=%0b addr=%0h expected 0/0", mem_read, address); end
    checks++; if (if_ack !== 1'b1 || if_err !== 1'b0 || ls_ack !== 1'b0) begin
      errors++; $display("FAIL if_ack: got ack=%0b err=%0b ls_ack=%0b expected 1/0/0", if_ack, if_err, ls_ack); end
    checks++; if (if_rdata !== 64'h0000_0000_DEAD_BEEF) begin
      errors++; $display("FAIL if_rdata: got %0h expected 00000000deadbeef", if_rdata); end
    if_req = 1'b0;
    @(posedge clock); #1;
    checks++; if (if_ack !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL if_after_ack: got ack=%0b busy=%0b expected 0/0", if_ack, busy); end
  endtask

  task automatic test_store();
    int nwr = 0;
    int nack = 0;
    int ack_cyc = 0;
    bit rd_seen = 1'b0;
    bit data_bad = 1'b0;
    bit err_seen = 1'b0;
    ls_we = 1'b1;
    ls_size = 2'b11;
    ls_addr = 32'h208;
    ls_wdata = 64'hA5A5_0000_FFFF_0001;
    ls_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (mem_write) begin
        nwr++;
        if (mem_wdata !== 64'hA5A5_0000_FFFF_0001 || mem_wdata_oe !== 1'b1 || address !== 32'h208 || size !== 2'b11)
          data_bad = 1'b1;
      end
      if (mem_read) rd_seen = 1'b1;
      if (ls_ack) begin
        nack++;
        if (ack_cyc == 0) ack_cyc = c;
        if (ls_err) err_seen = 1'b1;
        ls_req = 1'b0;
      end
    end
    checks++; if (nwr !== 2) begin errors++; $display("FAIL st_write_cycles: got %0d expected 2", nwr); end
    checks++; if (data_bad !== 1'b0) begin errors++; $display("FAIL st_bus_data: got bad=%0b expected 0", data_bad); end
    checks++; if (rd_seen !== 1'b0) begin errors++; $display("FAIL st_no_read: got %0b expected 0", rd_seen); end
    checks++; if (ack_cyc !== 3 || nack !== 1) begin
      errors++; $display("FAIL st_ack: got cycle=%0d count=%0d expected 3/1", ack_cyc, nack); end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL st_err: got %0b expected 0", err_seen); end
    ls_we = 1'b0;
  endtask

  task automatic test_round_robin();
    int n = 0;
    int ack_cyc[4];
    bit ack_ls[4];
    bit both = 1'b0;
    bit rdata_bad = 1'b0;
    mem_rdata = 64'h1234_5678_DEAD_BEEF;
    if_addr = 32'h500;
    ls_addr = 32'h400;
    ls_size = 2'b10;
    ls_we = 1'b0;
    if_req = 1'b1;
    ls_req = 1'b1;
    apply_reset();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (if_ack && ls_ack) both = 1'b1;
      if ((if_ack || ls_ack) && n < 4) begin
        ack_cyc[n] = c;
        ack_ls[n] = ls_ack;
        if (ls_ack && ls_rdata !== 64'h1234_5678_DEAD_BEEF) rdata_bad = 1'b1;
        n++;
        if (n == 4) begin if_req = 1'b0; ls_req = 1'b0; end
      end
    end
    checks++; if (n !== 4 || both !== 1'b0) begin
      errors++; $display("FAIL rr_count: got acks=%0d both=%0b expected 4/0", n, both); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (ack_ls[i] !== bit'(i % 2) || ack_cyc[i] !== 3 + 4 * i) begin
        errors++;
        $display("FAIL rr_grant%0d: got ls=%0b cycle=%0d expected ls=%0b cycle=%0d", i, ack_ls[i], ack_cyc[i], i % 2, 3 + 4 * i);
      end
    end
    checks++; if (rdata_bad !== 1'b0) begin errors++; $display("FAIL rr_ls_rdata: got bad=%0b expected 0", rdata_bad); end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_misaligned();
    ls_we = 1'b0;
    ls_size = 2'b10;
    ls_addr = 32'h202;
    ls_req = 1'b1;
    @(posedge clock); #1;
    checks++; if (ls_ack !== 1'b1 || ls_err !== 1'b1 || if_ack !== 1'b0) begin
      errors++; $display("FAIL mis_ack_err: got ack=%0b err=%0b if_ack=%0b expected 1/1/0", ls_ack, ls_err, if_ack); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL mis_no_strobe: got rd=%0b wr=%0b expected 0/0", mem_read, mem_write); end
    checks++; if (ls_rdata !== 64'h1234_5678_DEAD_BEEF) begin
      errors++; $display("FAIL mis_rdata_kept: got %0h expected 12345678deadbeef", ls_rdata); end
    ls_addr = 32'h200;
    @(posedge clock); #1;
    checks++; if (ls_ack !== 1'b0 || ls_err !== 1'b0 || busy !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL mis_idle: got ack=%0b err=%0b busy=%0b rd=%0b expected 0", ls_ack, ls_err, busy, mem_read); end
    @(posedge clock); #1;
    checks++; if (mem_read !== 1'b1 || address !== 32'h200) begin
      errors++; $display("FAIL mis_next_req: got rd=%0b addr=%0h expected 1/200", mem_read, address); end
    repeat (2) @(posedge clock);
    #1;
    checks++; if (ls_ack !== 1'b1 || ls_err !== 1'b0) begin
      errors++; $display("FAIL mis_next_ack: got ack=%0b err=%0b expected 1/0", ls_ack, ls_err); end
    ls_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    int nack = 0;
    int ack_cyc = 0;
    mem_rdata = 64'hCAFE_F00D_0123_4567;
    ls_we = 1'b0;
    ls_size = 2'b10;
    ls_addr = 32'h300;
    ls_req = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (mem_read !== 1'b1 || address !== 32'h300) begin
      errors++; $display("FAIL rm_second_cycle: got rd=%0b addr=%0h expected 1/300", mem_read, address); end
    #3 reset = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || busy !== 1'b0 || address !== 32'h0) begin
      errors++; $display("FAIL rm_async_drop: got rd=%0b busy=%0b addr=%0h expected 0", mem_read, busy, address); end
    repeat (2) begin
      @(posedge clock); #1;
      if (ls_ack) nack++;
    end
    reset = 1'b1;
    checks++; if (nack !== 0) begin errors++; $display("FAIL rm_no_ack: got %0d acks expected 0", nack); end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (ls_ack && ack_cyc == 0) begin
        ack_cyc = c;
        ls_req = 1'b0;
        checks++; if (ls_rdata !== 64'hCAFE_F00D_0123_4567) begin
          errors++; $display("FAIL rm_rdata: got %0h expected cafef00d01234567", ls_rdata); end
      end
    end
    checks++; if (ack_cyc !== 3) begin errors++; $display("FAIL rm_resume_ack: got cycle %0d expected 3", ack_cyc); end
    ls_req = 1'b0;
  endtask

  task automatic test_lat1();
    int nrd = 0;
    int nbusy = 0;
    int nack = 0;
    int ack_cyc = 0;
    bit wr_seen = 1'b0;
    ls_req = 1'b0;
    if_req = 1'b0;
    apply_reset();
    mem_rdata = 64'h0BAD_F00D_5555_AAAA;
    ls_we = 1'b0;
    ls_size = 2'b10;
    ls_addr = 32'h10;
    ls_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock); #1;
      if (d1_mem_read) nrd++;
      if (d1_mem_write) wr_seen = 1'b1;
      if (d1_busy) nbusy++;
      if (d1_ls_ack) begin
        nack++;
        if (ack_cyc == 0) ack_cyc = c;
        ls_req = 1'b0;
      end
    end
    checks++; if (nrd !== 1 || wr_seen !== 1'b0) begin
      errors++; $display("FAIL l1_read_cycles: got rd=%0d wr=%0b expected 1/0", nrd, wr_seen); end
    checks++; if (nbusy !== 2) begin errors++; $display("FAIL l1_busy_cycles: got %0d expected 2", nbusy); end
    checks++; if (ack_cyc !== 2 || nack !== 1) begin
      errors++; $display("FAIL l1_ack: got cycle=%0d count=%0d expected 2/1", ack_cyc, nack); end
    checks++; if (d1_ls_rdata !== 64'h0BAD_F00D_5555_AAAA || d1_ls_err !== 1'b0) begin
      errors++; $display("FAIL l1_rdata: got %0h err=%0b expected 0badf00d5555aaaa/0", d1_ls_rdata, d1_ls_err); end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    ls_req = 1'b0;
    ls_we = 1'b0;
    ls_size = 2'b00;
    ls_addr = '0;
    ls_wdata = '0;
    mem_rdata = '0;
    test_reset();
    test_if_fetch();
    test_store();
    test_round_robin();
    test_misaligned();
    test_reset_mid();
    test_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
